// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen APB initiator: FSM state encoding and
// response status codes.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_RESPONSE = 2'd3
  } apb_state_e;

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_ERROR  = 2'b11;

endpackage

// File: rtl/rggen_apb_initiator_timer.sv
// ACCESS-phase watchdog: a down-counter that is loaded in SETUP, counts ACCESS
// cycles and flags the last allowed cycle. Used only with RGGEN_APB_INITIATOR_TIMEOUT_EN.
module rggen_apb_initiator_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_active,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Loaded with N-1 so the terminal count lines up with the Nth ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (i_active && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = i_active && (r_count == '0);

endmodule

// File: rtl/rggen_apb_initiator.sv
// Command-to-APB bridge: turns a valid/ready command into one APB transfer and
// returns a valid/ready response. ACCESS timeout enabled by RGGEN_APB_INITIATOR_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | ready for a command
// SETUP    | psel=1, penable=0 for one cycle
// ACCESS   | psel=1, penable=1 until pready (or timeout)
// RESPONSE | response valid until consumed
module rggen_apb_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_WIDTH  = 16,
  parameter logic [2:0] PPROT          = 3'b000,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_command_valid,
  output logic                       o_command_ready,
  input  logic                       i_write,
  input  logic                       i_read,
  input  logic [ADDRESS_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]      i_write_data,
  input  logic [DATA_WIDTH/8-1:0]    i_write_strobe,
  output logic                       o_response_valid,
  input  logic                       i_response_ready,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic [1:0]                 o_status,
  output logic [ADDRESS_WIDTH-1:0]   o_paddr,
  output logic [2:0]                 o_pprot,
  output logic                       o_psel,
  output logic                       o_penable,
  output logic                       o_pwrite,
  output logic [DATA_WIDTH-1:0]      o_pwdata,
  output logic [DATA_WIDTH/8-1:0]    o_pstrb,
  input  logic                       i_pready,
  input  logic [DATA_WIDTH-1:0]      i_prdata,
  input  logic                       i_pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ADDRESS_WIDTH'(STRB_WIDTH - 1);

  apb_state_e                r_state;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [ADDRESS_WIDTH-1:0]  r_paddr;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic [STRB_WIDTH-1:0]     r_pstrb;
  logic                      r_response_valid;
  logic [DATA_WIDTH-1:0]     r_read_data;
  logic [1:0]                r_status;
  logic                      w_legal;
  logic                      w_timeout;

  assign w_legal = i_read ^ i_write;

`ifdef RGGEN_APB_INITIATOR_TIMEOUT_EN
  rggen_apb_initiator_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == ST_SETUP),
    .i_active  (r_state == ST_ACCESS),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_psel           <= 1'b0;
      r_penable        <= 1'b0;
      r_pwrite         <= 1'b0;
      r_paddr          <= '0;
      r_pwdata         <= '0;
      r_pstrb          <= '0;
      r_response_valid <= 1'b0;
      r_read_data      <= '0;
      r_status         <= STATUS_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_command_valid && w_legal) begin
            r_state  <= ST_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= i_write;
            r_paddr  <= i_address & ~ADDR_MASK;
            r_pwdata <= i_write ? i_write_data : '0;
            r_pstrb  <= i_write ? i_write_strobe : '0;
          end else if (i_command_valid) begin
            // Malformed command: answer with an error, never touch the bus.
            r_state          <= ST_RESPONSE;
            r_response_valid <= 1'b1;
            r_read_data      <= '0;
            r_status         <= STATUS_ERROR;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            r_state          <= ST_RESPONSE;
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_response_valid <= 1'b1;
            r_read_data      <= r_pwrite ? '0 : i_prdata;
            r_status         <= i_pslverr ? STATUS_SLVERR : STATUS_OKAY;
          end else if (w_timeout) begin
            r_state          <= ST_RESPONSE;
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_response_valid <= 1'b1;
            r_read_data      <= '0;
            r_status         <= STATUS_ERROR;
          end
        end
        ST_RESPONSE: begin
          if (i_response_ready) begin
            r_state          <= ST_IDLE;
            r_response_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_command_ready  = (r_state == ST_IDLE);
  assign o_response_valid = r_response_valid;
  assign o_read_data      = r_read_data;
  assign o_status         = r_status;
  assign o_paddr          = r_paddr;
  assign o_pprot          = PPROT;
  assign o_psel           = r_psel;
  assign o_penable        = r_penable;
  assign o_pwrite         = r_pwrite;
  assign o_pwdata         = r_pwdata;
  assign o_pstrb          = r_pstrb;

endmodule

// File: tb/tb_rggen_apb_initiator.sv
// Self-checking bench for rggen_apb_initiator; timeout case runs only when
// RGGEN_APB_INITIATOR_TIMEOUT_EN is defined.
module tb_rggen_apb_initiator;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_command_valid = 1'b0;
  logic        o_command_ready;
  logic        i_write = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [31:0] i_write_data = '0;
  logic [3:0]  i_write_strobe = '0;
  logic        o_response_valid;
  logic        i_response_ready = 1'b1;
  logic [31:0] o_read_data;
  logic [1:0]  o_status;
  logic [15:0] o_paddr;
  logic [2:0]  o_pprot;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready = 1'b0;
  logic [31:0] i_prdata = '0;
  logic        i_pslverr = 1'b0;

  int    n_checks = 0;
  int    n_pass = 0;
  resp_t sb[$];
  resp_t mon_e;

  rggen_apb_initiator #(
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (16),
    .PPROT          (3'b101),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .o_command_ready  (o_command_ready),
    .i_write          (i_write),
    .i_read           (i_read),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_write_strobe   (i_write_strobe),
    .o_response_valid (o_response_valid),
    .i_response_ready (i_response_ready),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Response monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_response_valid && i_response_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_resp", {o_read_data, o_status}, {mon_e.data, mon_e.status});
      end
    end
  end

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && !o_command_ready; k++) @(negedge clk);
    check({tag, "_idle"}, o_command_ready, 1'b1);
  endtask

  task automatic drive_cmd(input bit wr, input bit rd, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    i_command_valid = 1'b1;
    i_write         = wr;
    i_read          = rd;
    i_address       = addr;
    i_write_data    = wdata;
    i_write_strobe  = strb;
    @(posedge clk);
    #1;
    i_command_valid = 1'b0;
    i_write         = 1'b0;
    i_read          = 1'b0;
    i_address       = 16'($urandom);
    i_write_data    = $urandom;
  endtask

  task automatic apb_txn(input string tag, input bit wr, input bit rd,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits,
                         input logic [31:0] rdata, input bit err, input int hold);
    logic [15:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    bit          legal;
    bit          stable;
    resp_t       e;
    exp_addr = addr & 16'hFFFC;
    exp_wd   = wr ? wdata : 32'h0;
    exp_st   = wr ? strb : 4'h0;
    legal    = wr ^ rd;
    e.data   = (legal && rd) ? rdata : 32'h0;
    e.status = !legal ? 2'b11 : (err ? 2'b10 : 2'b00);
    wait_idle(tag);
    sb.push_back(e);
    i_response_ready = (hold == 0);
    drive_cmd(wr, rd, addr, wdata, strb);
    @(negedge clk);
    if (!legal) begin
      check({tag, "_no_psel"}, {o_psel, o_penable, o_response_valid}, 3'b001);
    end else begin
      check({tag, "_setup"}, {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb},
            {1'b1, 1'b0, wr, exp_addr, exp_wd, exp_st});
      stable = 1'b1;
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk);
        if ({o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_response_valid} !=
            {1'b1, 1'b1, wr, exp_addr, exp_wd, exp_st, 1'b0}) stable = 1'b0;
        if (k == waits) begin
          i_pready = 1'b1; i_prdata = rdata; i_pslverr = err;
        end else begin
          i_pready = 1'b0; i_prdata = $urandom; i_pslverr = 1'($urandom);
        end
      end
      check({tag, "_access_stable"}, stable, 1'b1);
      @(posedge clk);
      #1;
      i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = $urandom;
      @(negedge clk);
      check({tag, "_resp_latency"}, {o_response_valid, o_psel, o_penable}, 3'b100);
    end
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        if ({o_response_valid, o_read_data, o_status, o_command_ready} !=
            {1'b1, e.data, e.status, 1'b0}) stable = 1'b0;
        @(posedge clk);
        #1;
        if (k == hold - 1) i_response_ready = 1'b1;
        @(negedge clk);
      end
      check({tag, "_hold_stable"}, stable, 1'b1);
    end
    check({tag, "_busy_on_consume"}, {o_response_valid, o_command_ready}, 2'b10);
    @(negedge clk);
    check({tag, "_back_idle"}, {o_response_valid, o_command_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    seen;
    resp_t e;
    #12;
    check("reset_outputs",
          {o_command_ready, o_response_valid, o_psel, o_penable, o_pwrite, o_pprot,
           o_paddr, o_status, o_pstrb},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 16'h0, 2'b00, 4'h0});
    check("reset_data", {o_read_data, o_pwdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    apb_txn("wr_basic",  1, 0, 16'h0010, 32'hA5A5_5A5A, 4'hF, 0, 32'h0,         0, 0);
    apb_txn("rd_wait3",  0, 1, 16'h0006, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 0, 0);
    apb_txn("wr_slverr", 1, 0, 16'h0020, 32'h0BAD_F00D, 4'h5, 1, 32'h0,         1, 0);
    apb_txn("rd_slverr", 0, 1, 16'h0033, 32'h0,         4'h0, 2, 32'hCAFE_0001, 1, 0);
    apb_txn("both",      1, 1, 16'h0040, 32'h1111_1111, 4'hF, 0, 32'h0,         0, 0);
    apb_txn("neither",   0, 0, 16'h0044, 32'h2222_2222, 4'hF, 0, 32'h0,         0, 0);
    apb_txn("rd_hold5",  0, 1, 16'h0100, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 0, 5);
    apb_txn("wr_unalign",1, 0, 16'h00FF, 32'h89AB_CDEF, 4'h3, 2, 32'h0,         0, 0);
    apb_txn("both_hold", 1, 1, 16'h0008, 32'h0,         4'h0, 0, 32'h0,         0, 3);

    // Reset in the middle of ACCESS: bus drops at once and nothing is answered.
    wait_idle("rst_abort");
    drive_cmd(0, 1, 16'h0200, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_abort_in_access", {o_psel, o_penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("rst_abort_immediate",
          {o_psel, o_penable, o_response_valid, o_command_ready, o_paddr},
          {1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_response_valid || o_psel) seen = 1'b1;
    end
    check("rst_abort_no_resp", seen, 1'b0);

`ifdef RGGEN_APB_INITIATOR_TIMEOUT_EN
    wait_idle("timeout");
    e.data = 32'h0;
    e.status = 2'b11;
    sb.push_back(e);
    i_response_ready = 1'b1;
    drive_cmd(0, 1, 16'h0300, 32'h0, 4'h0);
    @(negedge clk);
    check("timeout_setup", {o_psel, o_penable}, 2'b10);
    seen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ({o_psel, o_penable, o_response_valid} != 3'b110) seen = 1'b0;
    end
    check("timeout_access4", seen, 1'b1);
    @(negedge clk);
    check("timeout_resp", {o_response_valid, o_psel, o_penable}, 3'b100);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
